// File: rtl/sobel_pkg.sv
// Shared geometry, FSM state and pixel types for the Sobel M_AXIS transmit stage.
// Macro SOBEL_TX_PACK_EN selects one packed {gy,gx} word per pixel instead of two words.
package sobel_pkg;

    localparam int DEF_IMG_W = 128;
    localparam int DEF_IMG_H = 128;
    localparam int DEF_PIX_W = 8;
    localparam int OUT_W     = DEF_IMG_W - 2;
    localparam int OUT_H     = DEF_IMG_H - 2;

    // Valid convolution output drops the one-pixel border on every side.
    function automatic int words_per_frame(input int img_w, input int img_h);
`ifdef SOBEL_TX_PACK_EN
        return (img_w - 2) * (img_h - 2);
`else
        return 2 * (img_w - 2) * (img_h - 2);
`endif
    endfunction

    localparam int WORDS_PER_FRAME = words_per_frame(DEF_IMG_W, DEF_IMG_H);

    typedef enum logic [1:0] {IDLE, SEND_GX, SEND_GY} tx_state_t;
    typedef logic [DEF_PIX_W-1:0] pixel_t;

endpackage

// File: rtl/sobel_pair_fifo.sv
// Synchronous FIFO for {gy,gx} result pairs; the extra pointer bit separates full from empty.
module sobel_pair_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] wdata,
    output logic [WIDTH-1:0] rdata,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic             do_push, do_pop;

    always_comb begin
        full     = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        empty    = (wr_ptr_q == rd_ptr_q);
        do_push  = push && !full;
        do_pop   = pop && !empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, do_push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, do_pop};
        rdata    = mem_q[rd_ptr_q[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/sobel_axis_tx.sv
// Sobel result transmit stage: buffers (gx,gy) pairs and streams them on M_AXIS with per-frame TLAST.
// Macro SOBEL_TX_PACK_EN packs each pair into a single word.
module sobel_axis_tx
    import sobel_pkg::*;
#(
    parameter int IMG_W      = DEF_IMG_W,
    parameter int IMG_H      = DEF_IMG_H,
    parameter int PIX_W      = DEF_PIX_W,
    parameter int DATA_W     = 32,
    parameter int FIFO_DEPTH = 8
) (
    input  logic              ACLK,
    input  logic              ARESET,
    input  logic              res_valid,
    output logic              res_ready,
    input  logic [PIX_W-1:0]  res_gx,
    input  logic [PIX_W-1:0]  res_gy,
    output logic              M_AXIS_TVALID,
    output logic [DATA_W-1:0] M_AXIS_TDATA,
    output logic              M_AXIS_TLAST,
    input  logic              M_AXIS_TREADY,
    output logic              frame_done,
    output logic [15:0]       frame_cnt
);
    localparam int WPF   = words_per_frame(IMG_W, IMG_H);
    localparam int CNT_W = $clog2(WPF + 1);
    localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WPF - 1);

    tx_state_t            state_q, state_d;
    logic [2*PIX_W-1:0]   hold_q, hold_d;
    logic [CNT_W-1:0]     word_cnt_q, word_cnt_d;
    logic [15:0]          frame_cnt_q, frame_cnt_d;
    logic                 frame_done_q, frame_done_d;
    logic                 fifo_full, fifo_empty, fifo_pop, beat;
    logic [2*PIX_W-1:0]   fifo_rdata;

    assign res_ready  = !fifo_full && !ARESET;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

    sobel_pair_fifo #(
        .WIDTH (2*PIX_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (ACLK),
        .rst   (ARESET),
        .push  (res_valid && res_ready),
        .pop   (fifo_pop),
        .wdata ({res_gy, res_gx}),
        .rdata (fifo_rdata),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_d       = state_q;
        hold_d        = hold_q;
        word_cnt_d    = word_cnt_q;
        frame_cnt_d   = frame_cnt_q;
        frame_done_d  = 1'b0;
        fifo_pop      = 1'b0;
        M_AXIS_TVALID = 1'b0;
        M_AXIS_TDATA  = '0;

        // TDATA comes only from hold_q, so it cannot move while a beat is stalled.
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    fifo_pop = 1'b1;
                    hold_d   = fifo_rdata;
                    state_d  = SEND_GX;
                end
            end
            SEND_GX: begin
                M_AXIS_TVALID = 1'b1;
`ifdef SOBEL_TX_PACK_EN
                M_AXIS_TDATA = DATA_W'(hold_q);
                if (M_AXIS_TREADY) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        hold_d   = fifo_rdata;
                    end else begin
                        state_d = IDLE;
                    end
                end
`else
                M_AXIS_TDATA = DATA_W'(hold_q[PIX_W-1:0]);
                if (M_AXIS_TREADY) state_d = SEND_GY;
`endif
            end
            SEND_GY: begin
                M_AXIS_TVALID = 1'b1;
                M_AXIS_TDATA  = DATA_W'(hold_q[2*PIX_W-1:PIX_W]);
                if (M_AXIS_TREADY) begin
                    if (!fifo_empty) begin
                        fifo_pop = 1'b1;
                        hold_d   = fifo_rdata;
                        state_d  = SEND_GX;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        beat         = M_AXIS_TVALID && M_AXIS_TREADY;
        M_AXIS_TLAST = M_AXIS_TVALID && (word_cnt_q == LAST_WORD);
        if (beat) begin
            if (word_cnt_q == LAST_WORD) begin
                word_cnt_d   = '0;
                frame_cnt_d  = frame_cnt_q + 16'd1;
                frame_done_d = 1'b1;
            end else begin
                word_cnt_d = word_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            state_q      <= IDLE;
            hold_q       <= '0;
            word_cnt_q   <= '0;
            frame_cnt_q  <= '0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            word_cnt_q   <= word_cnt_d;
            frame_cnt_q  <= frame_cnt_d;
            frame_done_q <= frame_done_d;
        end
    end

endmodule

// File: tb/tb_sobel_axis_tx.sv
// Self-checking bench for sobel_axis_tx: random stimulus against a queue-based word model.
// Builds with or without SOBEL_TX_PACK_EN; the reference model follows the same macro.
module tb_sobel_axis_tx;
    localparam int IMG_W      = 34;
    localparam int IMG_H      = 18;
    localparam int PIX_W      = 8;
    localparam int DATA_W     = 32;
    localparam int FIFO_DEPTH = 8;
    localparam int PAIRS      = (IMG_W - 2) * (IMG_H - 2);
`ifdef SOBEL_TX_PACK_EN
    localparam int WPF = PAIRS;
`else
    localparam int WPF = 2 * PAIRS;
`endif
    localparam int MID   = (WPF > 1000) ? 1000 : WPF / 2;
    localparam int GUARD = 20000;

    logic              ACLK = 1'b0;
    logic              ARESET = 1'b1;
    logic              res_valid = 1'b0;
    logic              res_ready;
    logic [PIX_W-1:0]  res_gx = '0;
    logic [PIX_W-1:0]  res_gy = '0;
    logic              M_AXIS_TVALID;
    logic [DATA_W-1:0] M_AXIS_TDATA;
    logic              M_AXIS_TLAST;
    logic              M_AXIS_TREADY = 1'b0;
    logic              frame_done;
    logic [15:0]       frame_cnt;

    int checks = 0;
    int errors = 0;
    logic [DATA_W-1:0] exp_q[$];
    int word_idx = 0;
    int frames = 0;
    int pairs_sent = 0;
    bit fd_exp = 1'b0;

    always #5 ACLK = ~ACLK;

    sobel_axis_tx #(
        .IMG_W(IMG_W), .IMG_H(IMG_H), .PIX_W(PIX_W), .DATA_W(DATA_W), .FIFO_DEPTH(FIFO_DEPTH)
    ) dut (
        .ACLK(ACLK), .ARESET(ARESET),
        .res_valid(res_valid), .res_ready(res_ready), .res_gx(res_gx), .res_gy(res_gy),
        .M_AXIS_TVALID(M_AXIS_TVALID), .M_AXIS_TDATA(M_AXIS_TDATA),
        .M_AXIS_TLAST(M_AXIS_TLAST), .M_AXIS_TREADY(M_AXIS_TREADY),
        .frame_done(frame_done), .frame_cnt(frame_cnt)
    );

    // Reference: each accepted pair becomes its output words, zero-extended.
    function automatic void model_push(input logic [7:0] gx, input logic [7:0] gy);
`ifdef SOBEL_TX_PACK_EN
        exp_q.push_back({16'h0, gy, gx});
`else
        exp_q.push_back({24'h0, gx});
        exp_q.push_back({24'h0, gy});
`endif
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        word_idx   = 0;
        frames     = 0;
        pairs_sent = 0;
        fd_exp     = 1'b0;
    endfunction

    task automatic test_reset();
        ARESET = 1'b1; res_valid = 1'b1; res_gx = 8'hFF; res_gy = 8'hFF; M_AXIS_TREADY = 1'b0;
        repeat (3) @(negedge ACLK);
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL reset_ready_low: got %b expected 0", res_ready); end
        ARESET = 1'b0; res_valid = 1'b0;
        @(negedge ACLK);
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL reset_tvalid: got %b expected 0", M_AXIS_TVALID); end
        checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL reset_tlast: got %b expected 0", M_AXIS_TLAST); end
        checks++; if (M_AXIS_TDATA !== 32'h0) begin errors++; $display("FAIL reset_tdata: got %h expected 0", M_AXIS_TDATA); end
        checks++; if (frame_done !== 1'b0) begin errors++; $display("FAIL reset_frame_done: got %b expected 0", frame_done); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL reset_frame_cnt: got %0d expected 0", frame_cnt); end
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL reset_ready_high: got %b expected 1", res_ready); end
        model_reset();
    endtask

    task automatic test_latency();
        logic [DATA_W-1:0] w;
        @(negedge ACLK);
`ifdef SOBEL_TX_PACK_EN
        res_gx = 8'hAB; res_gy = 8'hCD;
`else
        res_gx = 8'h12; res_gy = 8'h34;
`endif
        res_valid = 1'b1; M_AXIS_TREADY = 1'b1;
        checks++; if (res_ready !== 1'b1) begin errors++; $display("FAIL lat_ready: got %b expected 1", res_ready); end
        model_push(res_gx, res_gy); pairs_sent++;
        @(negedge ACLK);
        res_valid = 1'b0;
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL lat_early_valid: got %b expected 0", M_AXIS_TVALID); end
        @(negedge ACLK);
        checks++; if (M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL lat_valid: got %b expected 1", M_AXIS_TVALID); end
`ifdef SOBEL_TX_PACK_EN
        checks++; if (M_AXIS_TDATA !== 32'h0000CDAB) begin errors++; $display("FAIL lat_packed: got %h expected 0000cdab", M_AXIS_TDATA); end
`else
        checks++; if (M_AXIS_TDATA !== 32'h12) begin errors++; $display("FAIL lat_gx: got %h expected 00000012", M_AXIS_TDATA); end
`endif
        checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL lat_tlast0: got %b expected 0", M_AXIS_TLAST); end
        w = exp_q.pop_front(); word_idx++;
`ifndef SOBEL_TX_PACK_EN
        @(negedge ACLK);
        checks++; if (M_AXIS_TVALID !== 1'b1 || M_AXIS_TDATA !== 32'h34) begin
            errors++; $display("FAIL lat_gy: got v=%b %h expected v=1 00000034", M_AXIS_TVALID, M_AXIS_TDATA); end
        checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL lat_tlast1: got %b expected 0", M_AXIS_TLAST); end
        w = exp_q.pop_front(); word_idx++;
`endif
        @(negedge ACLK);
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL lat_drained: got %b expected 0 (w=%h)", M_AXIS_TVALID, w); end
        M_AXIS_TREADY = 1'b0;
    endtask

    task automatic test_backpressure();
        int acc = 0;
        M_AXIS_TREADY = 1'b0;
        repeat (20) begin
            @(negedge ACLK);
            res_valid = 1'b1; res_gx = 8'(pairs_sent); res_gy = ~8'(pairs_sent);
            if (M_AXIS_TVALID) begin
                checks++; if (M_AXIS_TDATA !== exp_q[0]) begin errors++; $display("FAIL bp_hold_data: got %h expected %h", M_AXIS_TDATA, exp_q[0]); end
            end
            if (res_ready) begin model_push(res_gx, res_gy); pairs_sent++; acc++; end
        end
        @(negedge ACLK);
        res_valid = 1'b0;
        checks++; if (acc !== FIFO_DEPTH + 1) begin errors++; $display("FAIL bp_accepted: got %0d expected %0d", acc, FIFO_DEPTH + 1); end
        checks++; if (res_ready !== 1'b0) begin errors++; $display("FAIL bp_ready: got %b expected 0", res_ready); end
        checks++; if (M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL bp_valid: got %b expected 1", M_AXIS_TVALID); end
    endtask

    task automatic test_frame_random(input int target, input int exp_frames);
        int guard = 0;
        logic [DATA_W-1:0] w;
        while ((pairs_sent < target || exp_q.size() != 0 || fd_exp) && guard < GUARD) begin
            @(negedge ACLK); guard++;
            res_valid = (pairs_sent < target) && ($urandom_range(0, 3) != 0);
            res_gx = 8'(pairs_sent); res_gy = ~8'(pairs_sent);
            M_AXIS_TREADY = 1'($urandom_range(0, 1));
            checks++; if (frame_done !== fd_exp) begin errors++; if (errors <= 50) $display("FAIL rnd_frame_done: got %b expected %b", frame_done, fd_exp); end
            fd_exp = 1'b0;
            if (M_AXIS_TVALID && M_AXIS_TREADY) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; if (errors <= 50) $display("FAIL rnd_extra_beat: got %h expected none", M_AXIS_TDATA); end
                else begin
                    w = exp_q.pop_front();
                    if (M_AXIS_TDATA !== w) begin errors++; if (errors <= 50) $display("FAIL rnd_tdata word %0d: got %h expected %h", word_idx, M_AXIS_TDATA, w); end
                end
                checks++; if (M_AXIS_TLAST !== 1'(word_idx == WPF - 1)) begin
                    errors++; if (errors <= 50) $display("FAIL rnd_tlast word %0d: got %b expected %b", word_idx, M_AXIS_TLAST, word_idx == WPF - 1); end
                if (word_idx == WPF - 1) begin word_idx = 0; frames++; fd_exp = 1'b1; end
                else word_idx++;
            end
            if (res_valid && res_ready) begin model_push(res_gx, res_gy); pairs_sent++; end
        end
        res_valid = 1'b0; M_AXIS_TREADY = 1'b0;
        checks++; if (guard >= GUARD) begin errors++; $display("FAIL rnd_timeout: got %0d cycles expected < %0d", guard, GUARD); end
        checks++; if (frames !== exp_frames) begin errors++; $display("FAIL rnd_frames: got %0d expected %0d", frames, exp_frames); end
        checks++; if (frame_cnt !== 16'(frames)) begin errors++; $display("FAIL rnd_frame_cnt: got %0d expected %0d", frame_cnt, frames); end
    endtask

    task automatic test_back_to_back(input int target);
        int guard = 0;
        int gaps = 0;
        bit gap_chk = 1'b0;
        logic [DATA_W-1:0] w;
        while ((pairs_sent < target || exp_q.size() != 0 || fd_exp) && guard < GUARD) begin
            @(negedge ACLK); guard++;
            res_valid = (pairs_sent < target);
            res_gx = 8'(pairs_sent); res_gy = ~8'(pairs_sent);
            M_AXIS_TREADY = 1'b1;
            checks++; if (frame_done !== fd_exp) begin errors++; if (errors <= 50) $display("FAIL b2b_frame_done: got %b expected %b", frame_done, fd_exp); end
            fd_exp = 1'b0;
            if (gap_chk) begin
                checks++; gaps++;
                if (M_AXIS_TVALID !== 1'b1) begin errors++; $display("FAIL b2b_bubble: got tvalid %b expected 1", M_AXIS_TVALID); end
            end
            gap_chk = 1'b0;
            if (M_AXIS_TVALID) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; if (errors <= 50) $display("FAIL b2b_extra_beat: got %h expected none", M_AXIS_TDATA); end
                else begin
                    w = exp_q.pop_front();
                    if (M_AXIS_TDATA !== w) begin errors++; if (errors <= 50) $display("FAIL b2b_tdata word %0d: got %h expected %h", word_idx, M_AXIS_TDATA, w); end
                end
                checks++; if (M_AXIS_TLAST !== 1'(word_idx == WPF - 1)) begin
                    errors++; if (errors <= 50) $display("FAIL b2b_tlast word %0d: got %b expected %b", word_idx, M_AXIS_TLAST, word_idx == WPF - 1); end
                if (word_idx == WPF - 1) begin
                    word_idx = 0; frames++; fd_exp = 1'b1;
                    gap_chk = (exp_q.size() != 0);
                end else word_idx++;
            end
            if (res_valid && res_ready) begin model_push(res_gx, res_gy); pairs_sent++; end
        end
        res_valid = 1'b0; M_AXIS_TREADY = 1'b0;
        checks++; if (guard >= GUARD) begin errors++; $display("FAIL b2b_timeout: got %0d cycles expected < %0d", guard, GUARD); end
        checks++; if (gaps < 1) begin errors++; $display("FAIL b2b_boundary: got %0d boundaries expected >= 1", gaps); end
        checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL b2b_frame_cnt: got %0d expected 3", frame_cnt); end
    endtask

    task automatic test_reset_midframe();
        int guard = 0;
        logic [DATA_W-1:0] w;
        while (word_idx != MID && guard < GUARD) begin
            @(negedge ACLK); guard++;
            res_valid = 1'b1; res_gx = 8'(pairs_sent); res_gy = ~8'(pairs_sent);
            M_AXIS_TREADY = 1'b1;
            fd_exp = 1'b0;
            if (M_AXIS_TVALID) begin
                checks++;
                if (exp_q.size() == 0) begin errors++; if (errors <= 50) $display("FAIL mid_extra_beat: got %h expected none", M_AXIS_TDATA); end
                else begin
                    w = exp_q.pop_front();
                    if (M_AXIS_TDATA !== w) begin errors++; if (errors <= 50) $display("FAIL mid_tdata word %0d: got %h expected %h", word_idx, M_AXIS_TDATA, w); end
                end
                if (word_idx == WPF - 1) begin word_idx = 0; frames++; end
                else word_idx++;
            end
            if (res_ready) begin model_push(res_gx, res_gy); pairs_sent++; end
        end
        checks++; if (guard >= GUARD) begin errors++; $display("FAIL mid_timeout: got %0d cycles expected < %0d", guard, GUARD); end
        @(negedge ACLK);
        ARESET = 1'b1; res_valid = 1'b0; M_AXIS_TREADY = 1'b0;
        @(negedge ACLK);
        checks++; if (M_AXIS_TVALID !== 1'b0) begin errors++; $display("FAIL mid_tvalid: got %b expected 0", M_AXIS_TVALID); end
        checks++; if (M_AXIS_TLAST !== 1'b0) begin errors++; $display("FAIL mid_tlast: got %b expected 0", M_AXIS_TLAST); end
        checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt: got %0d expected 0", frame_cnt); end
        ARESET = 1'b0;
        model_reset();
    endtask

    initial begin
        test_reset();
        test_latency();
        test_backpressure();
        test_frame_random(PAIRS, 1);
        test_back_to_back(3 * PAIRS);
        test_reset_midframe();
        test_frame_random(PAIRS, 1);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
